// File: rtl/pfe_pkg.sv
// Shared types and constants for the parallel 3x3 filter engine.
// Contents: kernel mode enum, FSM state enum, per-mode tap weights,
// box-filter scaling constants and an index-width helper.
package pfe_pkg;

    typedef enum logic [1:0] {
        MODE_BOX   = 2'b00,
        MODE_GAUSS = 2'b01,
        MODE_SHARP = 2'b10,
        MODE_PASS  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam int unsigned NUM_TAPS    = 9;
    localparam int unsigned FETCH_LAST  = 9;
    localparam int unsigned BOX_MUL     = 57;
    localparam int unsigned BOX_SHIFT   = 9;
    localparam int unsigned GAUSS_SHIFT = 4;

    // Signed weight per tap, taps in row-major order (tap 4 is the centre).
    localparam logic signed [3:0] TAP_WEIGHT [4][NUM_TAPS] = '{
        '{4'sd1, 4'sd1, 4'sd1, 4'sd1, 4'sd1, 4'sd1, 4'sd1, 4'sd1, 4'sd1},
        '{4'sd1, 4'sd2, 4'sd1, 4'sd2, 4'sd4, 4'sd2, 4'sd1, 4'sd2, 4'sd1},
        '{4'sd0, -4'sd1, 4'sd0, -4'sd1, 4'sd5, -4'sd1, 4'sd0, -4'sd1, 4'sd0},
        '{4'sd0, 4'sd0, 4'sd0, 4'sd0, 4'sd1, 4'sd0, 4'sd0, 4'sd0, 4'sd0}
    };

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/parallel_filter_engine_if.sv
// Tile-load, control and result-stream signals of the filter engine.
// master: tile loader / sink side; slave: the engine.
interface parallel_filter_engine_if #(
    parameter int unsigned NUM_CH = 16,
    parameter int unsigned TILE   = 64,
    parameter int unsigned PIX_W  = 8
);
    import pfe_pkg::*;

    localparam int unsigned P    = TILE + 2;
    localparam int unsigned CH_W = idx_w(NUM_CH);
    localparam int unsigned AW   = idx_w(P * P);
    localparam int unsigned RC_W = idx_w(TILE);

    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [AW-1:0]    wr_addr;
    logic [PIX_W-1:0] wr_data;
    logic             start;
    logic [1:0]       mode;
    logic             busy;
    logic             done;
    logic             out_valid;
    logic             out_ready;
    logic [CH_W-1:0]  out_ch;
    logic [RC_W-1:0]  out_row;
    logic [RC_W-1:0]  out_col;
    logic [PIX_W-1:0] out_pixel;

    modport master (
        output wr_en, wr_ch, wr_addr, wr_data, start, mode, out_ready,
        input  busy, done, out_valid, out_ch, out_row, out_col, out_pixel
    );

    modport slave (
        input  wr_en, wr_ch, wr_addr, wr_data, start, mode, out_ready,
        output busy, done, out_valid, out_ch, out_row, out_col, out_pixel
    );

endinterface

// File: rtl/filter_kernel_mac.sv
// Per-channel 3x3 multiply-accumulate with mode-dependent scaling and clamp.
// Ports: clk, rst; clear/en control the accumulator; tap (0..8) and pix are
// the current tap sample; mode selects the kernel; result_c is the clamped
// result of the accumulator including the sample being added this cycle.
module filter_kernel_mac
    import pfe_pkg::*;
#(
    parameter int unsigned PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [3:0]       tap,
    input  logic [PIX_W-1:0] pix,
    input  mode_e            mode,
    output logic [PIX_W-1:0] result_c
);
    localparam int unsigned ACC_W   = PIX_W + 7;
    localparam int unsigned EXT_W   = ACC_W + 8;
    localparam int unsigned PIX_MAX = (1 << PIX_W) - 1;

    logic signed [ACC_W-1:0] acc_q, acc_d, term;
    logic signed [EXT_W-1:0] acc_ext, scaled;

    // Accumulate weighted tap; scale, then clamp to the pixel range.
    always_comb begin
        term    = ACC_W'(TAP_WEIGHT[mode][tap]) * $signed(ACC_W'(pix));
        acc_d   = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + term;
        end
        acc_ext = EXT_W'(acc_d);
        case (mode)
            MODE_BOX:   scaled = (acc_ext * $signed(EXT_W'(BOX_MUL))) >>> BOX_SHIFT;
            MODE_GAUSS: scaled = acc_ext >>> GAUSS_SHIFT;
            default:    scaled = acc_ext;
        endcase
        if (scaled[EXT_W-1]) begin
            result_c = '0;
        end else if (scaled > $signed(EXT_W'(PIX_MAX))) begin
            result_c = '1;
        end else begin
            result_c = scaled[PIX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/parallel_filter_engine.sv
// Multi-channel 3x3 tile filter: per-channel padded tile RAM, lock-step MACs,
// results serialised per pixel (channels ascending) on a valid/ready stream.
// Ports: clk, rst (sync, active-high); bus (slave) carries tile writes,
// start/mode, busy/done status and the out_* result stream.
module parallel_filter_engine
    import pfe_pkg::*;
#(
    parameter int unsigned NUM_CH = 16,
    parameter int unsigned TILE   = 64,
    parameter int unsigned PIX_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    parallel_filter_engine_if.slave  bus
);
    localparam int unsigned P     = TILE + 2;
    localparam int unsigned DEPTH = P * P;
    localparam int unsigned AW    = idx_w(DEPTH);
    localparam int unsigned CH_W  = idx_w(NUM_CH);
    localparam int unsigned RC_W  = idx_w(TILE);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [3:0]       k_q, k_d;
    logic [RC_W-1:0]  row_q, row_d, col_q, col_d;
    logic             busy_q, busy_d, done_q, done_d, out_valid_q, out_valid_d;
    logic [CH_W-1:0]  out_ch_q, out_ch_d;
    logic [RC_W-1:0]  out_row_q, out_row_d, out_col_q, out_col_d;
    logic [PIX_W-1:0] out_pixel_q, out_pixel_d;
    logic [PIX_W-1:0] res_q [NUM_CH];
    logic [PIX_W-1:0] res_d [NUM_CH];

    logic [PIX_W-1:0] mem [NUM_CH][DEPTH];
    logic [PIX_W-1:0] rd_data_q [NUM_CH];
    logic [PIX_W-1:0] mac_res_c [NUM_CH];
    logic [AW-1:0]    rd_addr_d;
    logic [3:0]       tap_k, mac_tap;
    logic             mac_clear, mac_en, wr_hit;
    logic [CH_W-1:0]  ch_next;

    // Tap address for the current fetch step; step 9 only collects data.
    always_comb begin
        tap_k     = (k_q < 4'(FETCH_LAST)) ? k_q : 4'd0;
        rd_addr_d = AW'((32'(row_q) + 32'(tap_k) / 3) * P + 32'(col_q) + 32'(tap_k) % 3);
        mac_clear = (state_q == S_FETCH) && (k_q == 4'd0);
        mac_en    = (state_q == S_FETCH) && (k_q != 4'd0);
        mac_tap   = mac_en ? (k_q - 4'd1) : 4'd0;
        wr_hit    = bus.wr_en && (state_q == S_IDLE) &&
                    (32'(bus.wr_ch) < NUM_CH) && (32'(bus.wr_addr) < DEPTH);
    end

    // Tile RAMs: one write port shared by channel select, one read per channel.
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            mem[bus.wr_ch][bus.wr_addr] <= bus.wr_data;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            rd_data_q[i] <= mem[i][rd_addr_d];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_mac
        filter_kernel_mac #(.PIX_W(PIX_W)) u_mac (
            .clk      (clk),
            .rst      (rst),
            .clear    (mac_clear),
            .en       (mac_en),
            .tap      (mac_tap),
            .pix      (rd_data_q[g]),
            .mode     (mode_q),
            .result_c (mac_res_c[g])
        );
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        k_d         = k_q;
        row_d       = row_q;
        col_d       = col_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_pixel_d = out_pixel_q;
        res_d       = res_q;
        ch_next     = CH_W'(out_ch_q + 1'b1);

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    mode_d  = mode_e'(bus.mode);
                    busy_d  = 1'b1;
                    k_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_FETCH: begin
                k_d = k_q + 4'd1;
                if (k_q == 4'(FETCH_LAST)) begin
                    // Last tap lands this cycle: snapshot every channel's result.
                    state_d     = S_DRAIN;
                    res_d       = mac_res_c;
                    out_valid_d = 1'b1;
                    out_ch_d    = '0;
                    out_row_d   = row_q;
                    out_col_d   = col_q;
                    out_pixel_d = mac_res_c[0];
                end
            end
            S_DRAIN: begin
                if (out_valid_q && bus.out_ready) begin
                    if (out_ch_q == CH_W'(NUM_CH - 1)) begin
                        out_valid_d = 1'b0;
                        if ((row_q == RC_W'(TILE - 1)) && (col_q == RC_W'(TILE - 1))) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_FETCH;
                            k_d     = '0;
                            if (col_q == RC_W'(TILE - 1)) begin
                                col_d = '0;
                                row_d = row_q + RC_W'(1);
                            end else begin
                                col_d = col_q + RC_W'(1);
                            end
                        end
                    end else begin
                        out_ch_d    = ch_next;
                        out_pixel_d = res_q[ch_next];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_BOX;
            k_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_pixel_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            k_q         <= k_d;
            row_q       <= row_d;
            col_q       <= col_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_pixel_q <= out_pixel_d;
            res_q       <= res_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_pixel = out_pixel_q;

endmodule
